// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC unit.
package pc_pkg;

    // Source of the next fetch address
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_RAS,
        SEL_FALLBACK,
        SEL_TRAP
    } pc_sel_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    // Only the two low target bits matter for INC of 2 or 4 bytes.
    function automatic logic is_aligned(input logic [1:0] target_lsb,
                                        input int unsigned inc);
        if (inc == 4)
            return target_lsb == 2'b00;
        else if (inc == 2)
            return !target_lsb[0];
        else
            return 1'b1;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty is ignored. Push+pop on a non-empty stack
// replaces the top entry in place.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [RAS_DEPTH-1:0][XLEN-1:0] entries;
    logic [PW-1:0]                  top_ptr;
    logic [CW-1:0]                  count;

    assign empty    = (count == '0);
    assign full     = (count == CW'(RAS_DEPTH));
    assign top_data = empty ? '0 : entries[top_ptr];

    // Buffer, pointer and occupancy update
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries <= '0;
            top_ptr <= '0;
            count   <= '0;
        end else if (push && pop && !empty) begin
            entries[top_ptr] <= push_data;
        end else if (push) begin
            entries[top_ptr + PW'(1)] <= push_data;
            top_ptr <= top_ptr + PW'(1);
            if (!full)
                count <= count + CW'(1);
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - PW'(1);
            count   <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with trap vector, alignment check and
// return-address stack for call/return redirects.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int              IALIGN       = 32,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_en,
    input  logic            branch_decision,
    input  logic            pc_immediate_jump,
    input  logic [XLEN-1:0] generated_immediate,
    input  logic [XLEN-1:0] pc_write_value,
    input  logic            ras_push,
    input  logic            ras_pop,
    input  logic            trap_req,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_add_inc,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misaligned
);

    localparam int INC = IALIGN / 8;

    pc_sel_e         sel;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            aligned;
    logic            stack_push;
    logic            stack_pop;

    assign pc_add_inc = pc_out + XLEN'(INC);

    // Stack only moves on an accepted, non-trapped cycle
    assign stack_push = ras_push && in_en && !trap_req;
    assign stack_pop  = ras_pop  && in_en && !trap_req;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (pc_add_inc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Next-PC source priority: trap, return, fallback, branch, sequential
    always_comb begin
        sel = SEL_SEQ;
        if (trap_req)
            sel = SEL_TRAP;
        else if (ras_pop && !ras_empty)
            sel = SEL_RAS;
        else if (ras_pop)
            sel = SEL_FALLBACK;
        else if (branch_decision)
            sel = SEL_BRANCH;
    end

    // Candidate target for the selected source
    always_comb begin
        target = pc_add_inc;
        case (sel)
            SEL_TRAP:     target = TRAP_VECTOR;
            SEL_RAS:      target = ras_top;
            SEL_FALLBACK: target = pc_write_value;
            SEL_BRANCH:   target = pc_immediate_jump ? pc_write_value
                                                     : pc_out + generated_immediate;
            default:      target = pc_add_inc;
        endcase
    end

    // Sequential path never needs checking; only redirects can be misaligned
    assign redirect = (sel == SEL_RAS) || (sel == SEL_FALLBACK) || (sel == SEL_BRANCH);
    assign aligned  = is_aligned(target[1:0], INC);

    // PC register and one-cycle misaligned flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_out     <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else if (trap_req) begin
            pc_out     <= TRAP_VECTOR;
            misaligned <= 1'b0;
        end else if (!in_en) begin
            misaligned <= 1'b0;
        end else if (redirect && !aligned) begin
            pc_out     <= TRAP_VECTOR;
            misaligned <= 1'b1;
        end else begin
            pc_out     <= target;
            misaligned <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: two instances (32-bit and 16-bit alignment) share
// stimulus; each is compared against a list-based reference model.
module tb_pc_ras_unit;

    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_en = 1'b0;
    logic        branch_decision = 1'b0;
    logic        pc_immediate_jump = 1'b0;
    logic [31:0] generated_immediate = '0;
    logic [31:0] pc_write_value = '0;
    logic        ras_push = 1'b0;
    logic        ras_pop = 1'b0;
    logic        trap_req = 1'b0;

    logic [31:0] pc32, inc32, top32, pc16, inc16, top16;
    logic        emp32, full32, mis32, emp16, full16, mis16;

    int errors = 0;
    int checks = 0;

    // Reference model state: index 0 = IALIGN 32, index 1 = IALIGN 16.
    // Stack is a plain list, oldest at [0], newest at [cnt-1].
    logic [31:0] m_pc  [2];
    logic        m_mis [2];
    logic [31:0] m_stk [2][4];
    int          m_cnt [2];

    always #5 clock = ~clock;

    pc_ras_unit #(.IALIGN(32)) dut32 (
        .clock(clock), .reset(reset), .in_en(in_en),
        .branch_decision(branch_decision), .pc_immediate_jump(pc_immediate_jump),
        .generated_immediate(generated_immediate), .pc_write_value(pc_write_value),
        .ras_push(ras_push), .ras_pop(ras_pop), .trap_req(trap_req),
        .pc_out(pc32), .pc_add_inc(inc32), .ras_top(top32),
        .ras_empty(emp32), .ras_full(full32), .misaligned(mis32)
    );

    pc_ras_unit #(.IALIGN(16)) dut16 (
        .clock(clock), .reset(reset), .in_en(in_en),
        .branch_decision(branch_decision), .pc_immediate_jump(pc_immediate_jump),
        .generated_immediate(generated_immediate), .pc_write_value(pc_write_value),
        .ras_push(ras_push), .ras_pop(ras_pop), .trap_req(trap_req),
        .pc_out(pc16), .pc_add_inc(inc16), .ras_top(top16),
        .ras_empty(emp16), .ras_full(full16), .misaligned(mis16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = 32'h0;
            m_mis[k] = 1'b0;
            m_cnt[k] = 0;
            for (int i = 0; i < 4; i++) m_stk[k][i] = 32'h0;
        end
    endtask

    task automatic model_step(input int k, input int unsigned inc);
        logic [31:0] tgt, ret;
        logic        red;
        if (trap_req) begin
            m_pc[k]  = TRAP;
            m_mis[k] = 1'b0;
        end else if (!in_en) begin
            m_mis[k] = 1'b0;
        end else begin
            ret = m_pc[k] + inc;
            red = 1'b1;
            if (ras_pop && m_cnt[k] > 0)      tgt = m_stk[k][m_cnt[k]-1];
            else if (ras_pop)                 tgt = pc_write_value;
            else if (branch_decision)         tgt = pc_immediate_jump ? pc_write_value
                                                                      : m_pc[k] + generated_immediate;
            else begin tgt = ret; red = 1'b0; end
            if (ras_push && ras_pop && m_cnt[k] > 0) begin
                m_stk[k][m_cnt[k]-1] = ret;
            end else if (ras_push) begin
                if (m_cnt[k] == 4) begin
                    for (int i = 0; i < 3; i++) m_stk[k][i] = m_stk[k][i+1];
                    m_stk[k][3] = ret;
                end else begin
                    m_stk[k][m_cnt[k]] = ret;
                    m_cnt[k]++;
                end
            end else if (ras_pop && m_cnt[k] > 0) begin
                m_cnt[k]--;
            end
            if (red && (tgt % inc) != 0) begin
                m_pc[k]  = TRAP;
                m_mis[k] = 1'b1;
            end else begin
                m_pc[k]  = tgt;
                m_mis[k] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("pc32",    pc32,   m_pc[0]);
        chk("inc32",   inc32,  m_pc[0] + 4);
        chk("top32",   top32,  (m_cnt[0] > 0) ? m_stk[0][m_cnt[0]-1] : 32'h0);
        chk("empty32", {31'b0, emp32},  {31'b0, m_cnt[0] == 0});
        chk("full32",  {31'b0, full32}, {31'b0, m_cnt[0] == 4});
        chk("mis32",   {31'b0, mis32},  {31'b0, m_mis[0]});
        chk("pc16",    pc16,   m_pc[1]);
        chk("inc16",   inc16,  m_pc[1] + 2);
        chk("top16",   top16,  (m_cnt[1] > 0) ? m_stk[1][m_cnt[1]-1] : 32'h0);
        chk("empty16", {31'b0, emp16},  {31'b0, m_cnt[1] == 0});
        chk("full16",  {31'b0, full16}, {31'b0, m_cnt[1] == 4});
        chk("mis16",   {31'b0, mis16},  {31'b0, m_mis[1]});
    endtask

    task automatic step(input logic en, input logic br, input logic pij,
                        input logic [31:0] imm, input logic [31:0] pwv,
                        input logic push, input logic pop, input logic trp);
        in_en = en; branch_decision = br; pc_immediate_jump = pij;
        generated_immediate = imm; pc_write_value = pwv;
        ras_push = push; ras_pop = pop; trap_req = trp;
        @(posedge clock);
        model_step(0, 4);
        model_step(1, 2);
        #1 check_all();
    endtask

    // Asynchronous reset asserted between edges, observed before any clock
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clock) reset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;

        // Advance a little, then reset mid-run
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("adv3", pc32, 32'd12);

        // Stall, relative branch, absolute jump
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall", pc32, 32'd12);
        step(1, 1, 0, 32'hFFFF_FFF8, 0, 0, 0, 0);
        chk("br_neg", pc32, 32'd4);
        step(1, 1, 1, 0, 32'h40, 0, 0, 0);
        chk("jalr", pc32, 32'h40);

        // Call / return
        step(1, 1, 1, 0, 32'h10, 0, 0, 0);
        step(1, 1, 1, 0, 32'h80, 1, 0, 0);
        chk("call_pc", pc32, 32'h80);
        chk("call_top", top32, 32'h14);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'h999, 0, 1, 0);
        chk("ret_pc", pc32, 32'h14);
        chk("ret_empty", {31'b0, emp32}, 32'd1);

        // Overflow: five calls, then four LIFO returns and an empty pop
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 32'h1000 * (i + 1), 1, 0, 0);
        chk("ovf_full", {31'b0, full32}, 32'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h7770, 0, 1, 0);
        step(1, 0, 0, 0, 32'h200, 0, 1, 0);
        chk("udf_pc", pc32, 32'h200);
        chk("udf_empty", {31'b0, emp32}, 32'd1);

        // Misaligned target: traps on IALIGN 32, accepted on IALIGN 16
        step(1, 1, 1, 0, 32'h42, 0, 0, 0);
        chk("mis_pc", pc32, TRAP);
        chk("mis_flag", {31'b0, mis32}, 32'd1);
        chk("mis16_pc", pc16, 32'h42);
        chk("mis16_inc", inc16, 32'h44);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("mis_clear", {31'b0, mis32}, 32'd0);

        // Trap while stalled, with a pending push that must be ignored
        step(1, 1, 1, 0, 32'h400, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        chk("trap_pc", pc32, TRAP);
        chk("trap_top", top32, 32'h108);

        // PC wrap-around
        step(1, 1, 1, 0, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap", pc32, 32'h0);

        // Simultaneous push and pop with one entry
        do_reset();
        step(1, 1, 1, 0, 32'h2C, 0, 0, 0);
        step(1, 1, 1, 0, 32'h20, 1, 0, 0);
        step(1, 0, 0, 0, 32'h555, 1, 1, 0);
        chk("pp_pc", pc32, 32'h30);
        chk("pp_top", top32, 32'h24);
        step(1, 0, 0, 0, 32'h600, 0, 1, 0);
        chk("pp_cnt1", pc32, 32'h24);
        chk("pp_empty", {31'b0, emp32}, 32'd1);
        // Push+pop on an empty stack behaves as push, target from pwv
        step(1, 0, 0, 0, 32'h80, 1, 1, 0);
        chk("pp_e_pc", pc32, 32'h80);
        chk("pp_e_top", top32, 32'h28);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm, pwv;
            imm = (32'($urandom_range(0, 511)) - 32'd256);
            if ($urandom_range(0, 7) != 0) imm = imm & 32'hFFFF_FFFC;
            pwv = $urandom;
            if ($urandom_range(0, 3) != 0) pwv = pwv & 32'hFFFF_FFFC;
            if (i == 200) do_reset();
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                 1'($urandom), imm, pwv,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
